// File: rtl/queue_server_if.sv
// Handshake bundle between the queue server and its queue / sequencer.
// The server side takes the slave modport; whoever drives the queue status takes master.
interface queue_server_if;
   logic       enable;
   logic       pause;
   logic [4:0] size;
   logic       push;
   logic [3:0] service_time;
   logic       pop;
   logic       busy;
   logic       done;
   logic [3:0] head;
   logic [7:0] served_count;

   modport master (
      output enable, pause, size, push, service_time,
      input  pop, busy, done, head, served_count
   );

   modport slave (
      input  enable, pause, size, push, service_time,
      output pop, busy, done, head, served_count
   );
endinterface

// File: rtl/queue_server.sv
// Queue server: fetches one entry from an external queue, holds it for a
// programmable service time, then reports completion and keeps a saturating tally.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for enable with a non-empty queue
// FETCH | pop asserted until the queue accepts it (push wins ties)
// SERVE | down-counting the service timer, frozen while pause=1
// DONE  | one-cycle completion pulse, then chain or go idle
module queue_server (
   input  logic           clk,
   input  logic           rst,
   queue_server_if.slave  qs
);

   typedef enum logic [1:0] {IDLE, FETCH, SERVE, DONE} state_t;

   state_t     state, state_nxt;
   logic [3:0] timer, timer_nxt;
   logic [3:0] head, head_nxt;
   logic [7:0] served_count, served_count_nxt;
   logic       accept;

   // The queue gives a simultaneous push priority unless it is already full.
   assign accept = (state == FETCH) && (qs.size != 5'd0) &&
                   !(qs.push && (qs.size < 5'd16));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         timer        <= 4'd0;
         head         <= 4'd0;
         served_count <= 8'd0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         head         <= head_nxt;
         served_count <= served_count_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      timer_nxt        = timer;
      head_nxt         = head;
      served_count_nxt = served_count;
      case (state)
         IDLE: begin
            if (qs.enable && (qs.size != 5'd0)) state_nxt = FETCH;
         end
         FETCH: begin
            if (accept) begin
               head_nxt  = head + 4'd1;
               timer_nxt = (qs.service_time == 4'd0) ? 4'd1 : qs.service_time;
               state_nxt = SERVE;
            end else if (qs.size == 5'd0) begin
               state_nxt = IDLE;
            end
         end
         SERVE: begin
            if (!qs.pause) begin
               timer_nxt = (timer == 4'd0) ? 4'd0 : timer - 4'd1;
               // Count on entry to DONE so the tally is current while done is high.
               if (timer <= 4'd1) begin
                  state_nxt = DONE;
                  if (served_count != 8'hFF) served_count_nxt = served_count + 8'd1;
               end
            end
         end
         DONE: begin
            state_nxt = (qs.enable && (qs.size != 5'd0)) ? FETCH : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign qs.pop          = (state == FETCH);
   assign qs.busy         = (state != IDLE);
   assign qs.done         = (state == DONE);
   assign qs.head         = head;
   assign qs.served_count = served_count;

endmodule

// File: doc/queue_server.md
QUEUE_SERVER -- requirements
Module: queue_server

Interface
REQ-001 clk  input  1  Single system clock; all state updates on rising edge.
REQ-002 rst  input  1  Reset; asynchronous, active-high.
REQ-003 enable  input  1  Service enable; 1 = server may start a new service.
REQ-004 pause  input  1  Freezes the service timer while 1.
REQ-005 size  input  5  Current queue occupancy, 0..16, registered in the queue.
REQ-006 push  input  1  Push request being presented to the same queue this cycle.
REQ-007 service_time  input  4  Service duration in cycles; 0 is treated as 1.
REQ-008 pop  output  1  Pop request to the queue.
REQ-009 busy  output  1  1 whenever state is not IDLE.
REQ-010 done  output  1  One-cycle pulse per completed service.
REQ-011 head  output  4  Slot index of the next entry to serve; mirrors the queue front pointer.
REQ-012 served_count  output  8  Total completed services, saturating.

Function
REQ-013 The block SHALL be a four-state FSM: IDLE, FETCH, SERVE, DONE.
REQ-014 IDLE -> FETCH when enable=1 and size>0; otherwise stay in IDLE.
REQ-015 In FETCH, pop SHALL be driven to 1 combinationally; pop is 0 in every other state.
REQ-016 A pop is accepted when pop=1, size>0, and not (push=1 and size<16); push has priority in the queue.
REQ-017 In FETCH, pop SHALL stay asserted until accepted, with no cycle limit.
REQ-018 On an accepted pop, head SHALL increment modulo 16 (15 -> 0), the timer SHALL load max(service_time,1), and the FSM SHALL go to SERVE.
REQ-019 FETCH with size=0 (no acceptance possible) SHALL return to IDLE without changing head.
REQ-020 In SERVE, the 4-bit timer SHALL decrement by 1 each cycle when pause=0 and hold when pause=1.
REQ-021 When the timer value is 1 and pause=0, the FSM SHALL go to DONE, so SERVE lasts exactly max(service_time,1) unpaused cycles.
REQ-022 In DONE, done=1 for that single cycle, and served_count SHALL increment by 1, saturating at 255.
REQ-023 DONE -> FETCH if enable=1 and size>0; otherwise DONE -> IDLE.
REQ-024 enable=0 SHALL NOT abort FETCH or SERVE; it only blocks starting a new service.
REQ-025 service_time SHALL be sampled only at pop acceptance; later changes do not affect the current service.
REQ-026 Minimum back-to-back throughput with service_time<=1 and no push collision: one pop every 3 cycles (FETCH, SERVE, DONE).
REQ-027 head SHALL change only on an accepted pop, so it stays equal to the queue front pointer when both come out of reset together.

Reset
REQ-028 On rst=1, asynchronously and regardless of clk:
- state = IDLE
- timer = 0
- head = 0
- served_count = 0
- pop = 0, busy = 0, done = 0
REQ-029 Reset asserted mid-service SHALL discard the service in progress with no done pulse; after release the block SHALL wait in IDLE for at least one clk edge.
REQ-030 All outputs SHALL be glitch-free registered or state-decoded values, except pop, which is decoded from state only.

Verification
REQ-031 Basic service: rst then release; size=3, enable=1, service_time=4, no push.
- Required: pop high for 1 cycle; busy=1; after 4 SERVE cycles done pulses once; served_count=1; head=1.
REQ-032 Push collision: in FETCH with size=5, hold push=1 for 3 cycles.
- Required: pop held high for 4 cycles; head increments only in the 4th cycle; exactly one acceptance.
REQ-033 Pause and zero time: service_time=0 with pause=1 for 2 cycles during SERVE.
- Required: SERVE lasts 3 cycles; done pulses once.
REQ-034 Wrap and saturation:
- Drive 17 services: head sequence 1..15, 0, 1.
- Preload 255 services, then complete one more: served_count stays 255.
REQ-035 Async reset mid-SERVE (timer=3): assert rst between clk edges.
- Required: busy, pop, head, served_count all 0 immediately; no done pulse.
REQ-036 Empty and disable:
- size=0 with enable=1: stays IDLE, pop never asserted.
- enable dropped during SERVE: service completes, done pulses, then IDLE.
